// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM between fetch and data ports, MEM over IF, programmable wait states
module sram_port_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_bwe,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic              pipe_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] REC  = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic       own_mem;
  logic       wr;
  logic       wr_grant;
  logic       unused;
  assign wr_grant   = mem_req & mem_wr;
  assign pipe_stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);
  assign unused     = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      own_mem    <= 1'b0;
      wr         <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= 32'h0;
      mem_rdata  <= 32'h0;
      sram_addr  <= '0;
      sram_dq_o  <= 32'h0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: if (mem_req | if_req) begin
          own_mem    <= mem_req;
          wr         <= wr_grant;
          sram_addr  <= mem_req ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          sram_dq_o  <= mem_wdata;
          sram_be_n  <= wr_grant ? ~mem_bwe : 4'h0;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= wr_grant;
          sram_we_n  <= ~wr_grant;
          sram_dq_oe <= wr_grant;
          cnt        <= 4'(WAIT_STATES);
          state      <= ACC;
        end
        ACC: if (cnt == 4'd0) begin
          if (!wr && own_mem) mem_rdata <= sram_dq_i;
          if (!wr && !own_mem) if_rdata <= sram_dq_i;
          mem_ack   <= own_mem;
          if_ack    <= ~own_mem;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= 4'hF;
          state     <= REC;
        end else begin
          cnt <= cnt - 4'd1;
        end
        REC: begin
          sram_dq_oe <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random and directed checks of sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;
  localparam int WS = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic if_req, mem_req, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0] mem_bwe;
  logic [31:0] if_rdata, mem_rdata;
  logic if_ack, mem_ack, pipe_stall;
  logic [17:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0] sram_be_n;
  logic [31:0] sram [256];
  logic [31:0] noise;
  logic filled = 1'b0;
  logic pl_en;
  logic [7:0] pl_addr;
  logic [31:0] pl_data;
  sram_port_arbiter #(.WAIT_STATES(WS), .ADDR_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bwe(mem_bwe), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pipe_stall(pipe_stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );
  always @(posedge clk) begin
    noise <= $urandom;
    if (!filled) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
      filled <= 1'b1;
    end else if (pl_en) begin
      sram[pl_addr] <= pl_data;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram[sram_addr[7:0]][b*8 +: 8] <= sram_dq_o[b*8 +: 8];
    end
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[7:0]] : noise;
  logic b_req, b_ack, b_stall, b_if_ack, b_dq_oe, b_ce_n, b_oe_n, b_we_n;
  logic [31:0] b_addr, b_rdata, b_if_rdata, b_dq_o, b_dq_i;
  logic [17:0] b_saddr;
  logic [3:0] b_be_n;
  assign b_dq_i = 32'hC0DE_0000 | {14'h0, b_saddr};
  sram_port_arbiter #(.WAIT_STATES(0), .ADDR_W(18)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .mem_req(b_req), .mem_wr(1'b0), .mem_addr(b_addr), .mem_wdata(32'h0),
    .mem_bwe(4'h0), .mem_rdata(b_rdata), .mem_ack(b_ack), .pipe_stall(b_stall),
    .sram_addr(b_saddr), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe), .sram_dq_i(b_dq_i),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n)
  );
  int n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] hold_if, hold_mem;
  int if_at, mem_at, n_if_ack, n_mem_ack, n_oe, n_we, n_cyc, if_glitch, mem_glitch;
  logic [3:0] be_w;
  logic [31:0] if_rd, mem_rd;
  logic [17:0] addr_if, addr_mem;
  logic [63:0] stall_vec;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int b = 0; b < 4; b++) merge[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
  endfunction
  function automatic logic [63:0] exp_stall(input int n, input int ti, input int tm);
    exp_stall = '0;
    for (int c = 0; c < n; c++) exp_stall[c] = (c < ti) || (c < tm);
  endfunction
  function automatic logic [31:0] baddr(input logic [7:0] w);
    baddr = {12'($urandom), 10'h0, w, 2'($urandom)};
  endfunction
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask
  task automatic drive(input logic di, input logic dm, input logic dw, input logic [31:0] ia,
                       input logic [31:0] ma, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] pif, pmem;
    if_req = di; if_addr = ia; mem_req = dm; mem_wr = dw; mem_addr = ma; mem_wdata = wd; mem_bwe = be;
    if_at = -1; mem_at = -1; n_if_ack = 0; n_mem_ack = 0; n_oe = 0; n_we = 0; n_cyc = 0;
    if_glitch = 0; mem_glitch = 0; be_w = 4'h0; stall_vec = '0;
    pif = if_rdata; pmem = mem_rdata;
    for (int c = 0; c < 40 && (if_req || mem_req); c++) begin
      @(negedge clk);
      n_cyc = c + 1;
      stall_vec[c] = pipe_stall;
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) begin n_we++; be_w = sram_be_n; end
      if (!if_ack && if_rdata !== pif) if_glitch++;
      if (!mem_ack && mem_rdata !== pmem) mem_glitch++;
      pif = if_rdata; pmem = mem_rdata;
      if (if_ack) begin n_if_ack++; if (if_at < 0) if_at = c; if_rd = if_rdata; addr_if = sram_addr; end
      if (mem_ack) begin n_mem_ack++; if (mem_at < 0) mem_at = c; mem_rd = mem_rdata; addr_mem = sram_addr; end
      @(posedge clk); #1;
      if (if_at == c) if_req = 1'b0;
      if (mem_at == c) mem_req = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    if (if_ack) n_if_ack++;
    if (mem_ack) n_mem_ack++;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; if_addr = '0; mem_addr = '0;
    mem_wdata = '0; mem_bwe = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0; b_req = 1'b0; b_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({if_ack, mem_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 10'b00_111_1111_0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0011111110",
        {if_ack, mem_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe});
    end
    n_chk++;
    if ({if_rdata, mem_rdata, sram_dq_o} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h want 0", if_rdata, mem_rdata, sram_dq_o);
    end
    n_chk++;
    if (sram_addr !== 18'h0 || pipe_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_addr got addr %h stall %b want 0 0", sram_addr, pipe_stall);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    hold_if = 32'h0; hold_mem = 32'h0;
  endtask
  task automatic test_if_read();
    preload(8'd4, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 4'h0);
    hold_if = 32'hDEAD_BEEF;
    n_chk++;
    if (if_at !== WS + 2 || n_if_ack !== 1 || n_mem_ack !== 0) begin
      n_fail++; $display("FAIL t1_ack got at %0d n %0d/%0d want at %0d n 1/0", if_at, n_if_ack, n_mem_ack, WS + 2);
    end
    n_chk++;
    if (if_rd !== 32'hDEAD_BEEF || addr_if !== 18'd4) begin
      n_fail++; $display("FAIL t1_data got %h addr %0d want deadbeef addr 4", if_rd, addr_if);
    end
    n_chk++;
    if (n_oe !== WS + 1 || n_we !== 0) begin
      n_fail++; $display("FAIL t1_strobes got oe %0d we %0d want %0d 0", n_oe, n_we, WS + 1);
    end
    n_chk++;
    if (stall_vec !== exp_stall(n_cyc, WS + 2, -1)) begin
      n_fail++; $display("FAIL t1_stall got %h want %h", stall_vec, exp_stall(n_cyc, WS + 2, -1));
    end
  endtask
  task automatic test_priority();
    logic [31:0] d;
    d = $urandom;
    preload(8'd16, d);
    ref_mem[8] = merge(ref_mem[8], 32'h1234_5678, 4'b0011);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0020, 32'h1234_5678, 4'b0011);
    hold_if = d;
    n_chk++;
    if (mem_at !== WS + 2 || if_at !== 2 * WS + 5) begin
      n_fail++; $display("FAIL t2_order got mem %0d if %0d want %0d %0d", mem_at, if_at, WS + 2, 2 * WS + 5);
    end
    n_chk++;
    if (be_w !== 4'b1100 || n_we !== WS + 1 || addr_mem !== 18'd8) begin
      n_fail++; $display("FAIL t2_write got be %b we %0d addr %0d want 1100 %0d 8", be_w, n_we, addr_mem, WS + 1);
    end
    n_chk++;
    if (sram[8] !== ref_mem[8] || if_rd !== d) begin
      n_fail++; $display("FAIL t2_data got %h %h want %h %h", sram[8], if_rd, ref_mem[8], d);
    end
    n_chk++;
    if (stall_vec !== exp_stall(n_cyc, 2 * WS + 5, WS + 2)) begin
      n_fail++; $display("FAIL t2_stall got %h want %h", stall_vec, exp_stall(n_cyc, 2 * WS + 5, WS + 2));
    end
  endtask
  task automatic test_back_to_back();
    int t1, t2;
    logic ea;
    t1 = 2; t2 = t1 + 3;
    b_req = 1'b1; b_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ea = (c == t1) || (c == t2);
      n_chk++;
      if (b_ack !== ea || b_stall !== (c <= t2 && !ea)) begin
        n_fail++; $display("FAIL t3_cycle%0d got ack %b stall %b want %b %b", c, b_ack, b_stall, ea, c <= t2 && !ea);
      end
      if (ea) begin
        n_chk++;
        if (b_rdata !== (32'hC0DE_0000 | (c == t1 ? 32'h0 : 32'h1))) begin
          n_fail++; $display("FAIL t3_rdata got %h at cycle %0d", b_rdata, c);
        end
      end
      @(posedge clk); #1;
      if (c == t1) b_addr = 32'h4;
      if (c == t2) b_req = 1'b0;
    end
  endtask
  task automatic test_reset_mid();
    int acks;
    preload(8'd12, 32'h0BAD_F00D);
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hFFFF_FFFF; mem_bwe = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0) begin
      n_fail++; $display("FAIL t4_in_acc got ce %b we %b want 0 0", sram_ce_n, sram_we_n);
    end
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    n_chk++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, sram_be_n} !== 8'b1110_1111) begin
      n_fail++; $display("FAIL t4_abort got %b want 11101111", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe, sram_be_n});
    end
    acks = 0;
    repeat (3) begin @(negedge clk); acks += int'(mem_ack) + int'(if_ack); end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); acks += int'(mem_ack) + int'(if_ack); end
    @(posedge clk); #1;
    n_chk++;
    if (acks !== 0) begin n_fail++; $display("FAIL t4_no_ack got %0d acks want 0", acks); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 32'h0, 4'h0);
    hold_mem = ref_mem[12];
    n_chk++;
    if (mem_rd !== 32'h0BAD_F00D || sram[12] !== 32'h0BAD_F00D || mem_at !== WS + 2) begin
      n_fail++; $display("FAIL t4_after got %h sram %h at %0d want 0badf00d at %0d", mem_rd, sram[12], mem_at, WS + 2);
    end
  endtask
  task automatic test_zero_bwe();
    drive(1'b0, 1'b1, 1'b1, 32'h0, baddr(8'd20), $urandom, 4'h0);
    n_chk++;
    if (mem_at !== WS + 2 || n_mem_ack !== 1 || n_we !== WS + 1 || be_w !== 4'hF) begin
      n_fail++; $display("FAIL t5_cycle got at %0d n %0d we %0d be %b want %0d 1 %0d 1111", mem_at, n_mem_ack, n_we, be_w, WS + 2, WS + 1);
    end
    n_chk++;
    if (sram[20] !== ref_mem[20] || mem_rdata !== hold_mem) begin
      n_fail++; $display("FAIL t5_unchanged got %h rd %h want %h %h", sram[20], mem_rdata, ref_mem[20], hold_mem);
    end
  endtask
  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b0, baddr(8'd33), 32'h0, 32'h0, 4'h0);
    hold_if = ref_mem[33];
    n_chk++;
    if (mem_glitch !== 0 || mem_rdata !== hold_mem || if_rd !== hold_if) begin
      n_fail++; $display("FAIL t6_if got rd %h mem %h glitch %0d want %h %h 0", if_rd, mem_rdata, mem_glitch, hold_if, hold_mem);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, baddr(8'd34), 32'h0, 4'h0);
    hold_mem = ref_mem[34];
    n_chk++;
    if (if_glitch !== 0 || if_rdata !== hold_if || mem_rd !== hold_mem) begin
      n_fail++; $display("FAIL t6_mem got if %h mem %h glitch %0d want %h %h 0", if_rdata, mem_rd, if_glitch, hold_if, hold_mem);
    end
  endtask
  task automatic test_random();
    logic di, dm, dw;
    logic [1:0] k;
    logic [7:0] iw, mw;
    logic [31:0] wd, em;
    logic [3:0] be;
    int ti, tm;
    for (int n = 0; n < 40; n++) begin
      k = 2'($urandom_range(1, 3));
      di = k[0]; dm = k[1]; dw = 1'($urandom);
      iw = 8'($urandom); mw = 8'($urandom); wd = $urandom; be = 4'($urandom);
      em = ref_mem[mw];
      if (dm && dw) ref_mem[mw] = merge(ref_mem[mw], wd, be);
      if (dm && !dw) hold_mem = em;
      if (di) hold_if = ref_mem[iw];
      tm = dm ? WS + 2 : -1;
      ti = di ? (dm ? 2 * WS + 5 : WS + 2) : -1;
      drive(di, dm, dw, baddr(iw), baddr(mw), wd, be);
      n_chk++;
      if (if_at !== ti || mem_at !== tm || n_if_ack !== int'(di) || n_mem_ack !== int'(dm)) begin
        n_fail++; $display("FAIL rnd%0d_ack got if %0d/%0d mem %0d/%0d want %0d/%0d %0d/%0d",
          n, if_at, n_if_ack, mem_at, n_mem_ack, ti, di, tm, dm);
      end
      n_chk++;
      if (if_rdata !== hold_if || mem_rdata !== hold_mem || if_glitch !== 0 || mem_glitch !== 0) begin
        n_fail++; $display("FAIL rnd%0d_rdata got %h %h g %0d %0d want %h %h", n, if_rdata, mem_rdata,
          if_glitch, mem_glitch, hold_if, hold_mem);
      end
      n_chk++;
      if (sram[mw] !== ref_mem[mw]) begin
        n_fail++; $display("FAIL rnd%0d_sram got %h want %h", n, sram[mw], ref_mem[mw]);
      end
      n_chk++;
      if (stall_vec !== exp_stall(n_cyc, ti, tm) || n_we !== ((dm && dw) ? WS + 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_stall got %h we %0d want %h", n, stall_vec, n_we, exp_stall(n_cyc, ti, tm));
      end
    end
  endtask
  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_zero_bwe();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
